// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release/long pulses.
// Define BTN_LONGPRESS_EN to enable the hold counter and long_pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] deb_cnt, deb_n;
    logic          pin, sync0, s_in;
    logic          press_n, release_n, level_n;

    assign pin = ACTIVE_LOW ? ~btn_in : btn_in;

    // Sync flops reset to the not-pressed value (after inversion)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            s_in  <= 1'b0;
        end else begin
            sync0 <= pin;
            s_in  <= sync0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            deb_cnt       <= deb_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        case (state)
            IDLE: begin
                if (s_in) begin
                    if (DEBOUNCE_MS == 1) begin
                        state_n = HELD;
                        deb_n   = '0;
                    end else begin
                        state_n = PRESS_WAIT;
                        deb_n   = DEB_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_n = IDLE;
                    deb_n   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = HELD;
                    deb_n   = '0;
                end else begin
                    deb_n = deb_cnt + DEB_ONE;
                end
            end
            HELD: begin
                if (!s_in) begin
                    if (DEBOUNCE_MS == 1) begin
                        state_n = IDLE;
                        deb_n   = '0;
                    end else begin
                        state_n = RELEASE_WAIT;
                        deb_n   = DEB_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s_in) begin
                    state_n = HELD;
                    deb_n   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = IDLE;
                    deb_n   = '0;
                end else begin
                    deb_n = deb_cnt + DEB_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                deb_n   = '0;
            end
        endcase
    end

    always_comb begin
        level_n   = (state_n == HELD) || (state_n == RELEASE_WAIT);
        press_n   = (state_n == HELD) &&
                    ((state == IDLE) || (state == PRESS_WAIT));
        release_n = (state_n == IDLE) &&
                    ((state == HELD) || (state == RELEASE_WAIT));
    end

`ifdef BTN_LONGPRESS_EN
    localparam int HW = $clog2(LONG_MS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0] hold_cnt;
    logic          long_done;
    logic          in_hold;

    assign in_hold = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_n)
                hold_cnt <= '0;
            else if (in_hold && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + HOLD_ONE;
            if (in_hold && !long_done && hold_cnt == HOLD_PRE) begin
                long_pulse <= 1'b1;
                long_done  <= 1'b1;
            end
            // Re-arm only once the button is fully released
            if (state_n == IDLE)
                long_done <= 1'b0;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed test plan plus random
// stimulus against a sliding-window debounce reference model.
module tb_btn_conditioner;

    localparam int DB[3] = '{20, 20, 1};
`ifdef BTN_LONGPRESS_EN
    localparam int LG[3] = '{1000, 1000, 5};
`endif

    logic       clk;
    logic       rst;
    logic [2:0] p;
    logic [2:0] btn;
    logic [2:0] lvl_o, press_o, rel_o, long_o;

    assign btn = p ^ 3'b010;

    btn_conditioner #(.DEBOUNCE_MS(20), .LONG_MS(1000), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst(rst), .btn_in(btn[0]), .btn_level(lvl_o[0]),
        .press_pulse(press_o[0]), .release_pulse(rel_o[0]), .long_pulse(long_o[0]));
    btn_conditioner #(.DEBOUNCE_MS(20), .LONG_MS(1000), .ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst(rst), .btn_in(btn[1]), .btn_level(lvl_o[1]),
        .press_pulse(press_o[1]), .release_pulse(rel_o[1]), .long_pulse(long_o[1]));
    btn_conditioner #(.DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b0)) u2 (
        .clk(clk), .rst(rst), .btn_in(btn[2]), .btn_level(lvl_o[2]),
        .press_pulse(press_o[2]), .release_pulse(rel_o[2]), .long_pulse(long_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    bit smp[3][$];
    bit mlvl[3];
    bit e_press[3], e_rel[3], e_long[3];
`ifdef BTN_LONGPRESS_EN
    int hcnt[3];
`endif

    int cnt_press[3], cnt_rel[3], cnt_long[3];
    int last_press[3], last_rel[3], last_long[3];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            smp[i].delete();
            mlvl[i] = 1'b0;
            e_press[i] = 1'b0;
            e_rel[i] = 1'b0;
            e_long[i] = 1'b0;
`ifdef BTN_LONGPRESS_EN
            hcnt[i] = 0;
`endif
        end
    endtask

    // The level flips once the last DB FSM-visible samples all disagree
    // with it; FSM sees the pin two edges after it is first sampled.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit lb, flip;
            smp[i].push_back(p[i]);
            if (smp[i].size() > 48) void'(smp[i].pop_front());
            lb = mlvl[i];
            flip = 1'b1;
            for (int j = 0; j < DB[i]; j++) begin
                int idx;
                bit v;
                idx = smp[i].size() - 3 - j;
                v = (idx >= 0) ? smp[i][idx] : 1'b0;
                if (v == lb) flip = 1'b0;
            end
            e_press[i] = flip && !lb;
            e_rel[i] = flip && lb;
            if (flip) mlvl[i] = !lb;
            e_long[i] = 1'b0;
`ifdef BTN_LONGPRESS_EN
            if (lb) begin
                hcnt[i]++;
                if (hcnt[i] == LG[i]) e_long[i] = 1'b1;
            end
            if (flip && !lb) hcnt[i] = 0;
`endif
        end
    endtask

    task automatic check_all(input string where);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.level@%0d", where, i, edge_n), lvl_o[i], mlvl[i]);
            chk($sformatf("%s.u%0d.press@%0d", where, i, edge_n), press_o[i], e_press[i]);
            chk($sformatf("%s.u%0d.release@%0d", where, i, edge_n), rel_o[i], e_rel[i]);
            chk($sformatf("%s.u%0d.long@%0d", where, i, edge_n), long_o[i], e_long[i]);
            if (press_o[i] === 1'b1) begin cnt_press[i]++; last_press[i] = edge_n; end
            if (rel_o[i] === 1'b1) begin cnt_rel[i]++; last_rel[i] = edge_n; end
            if (long_o[i] === 1'b1) begin cnt_long[i]++; last_long[i] = edge_n; end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
            last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
        end
    endtask

    task automatic step(input string where);
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        check_all(where);
    endtask

    task automatic run(input string where, input logic [2:0] pv, input int n);
        p = pv;
        for (int c = 0; c < n; c++) step(where);
    endtask

    // Called at a negedge: assert reset, check the async clear, release later
    task automatic hit_reset(input int n);
        rst = 1'b1;
        #1;
        model_clear();
        check_all("rst_assert");
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("rst_hold");
        end
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int rl[3];
        rst = 1'b0;
        p = 3'b000;
        model_clear();
        clear_counts();
        #2 rst = 1'b1;
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        edge_n = 0;

        // Clean press: pin sampled pressed on edges 10..109
        clear_counts();
        for (int e = 1; e <= 160; e++) begin
            p = (e >= 10 && e < 110) ? 3'b111 : 3'b000;
            step("clean");
        end
        chk_int("clean.u0.press_edge", last_press[0], 31);
        chk_int("clean.u0.release_edge", last_rel[0], 131);
        chk_int("clean.u1.press_edge", last_press[1], 31);
        chk_int("clean.u1.release_edge", last_rel[1], 131);
        chk_int("clean.u2.press_edge", last_press[2], 12);
        chk_int("clean.u2.release_edge", last_rel[2], 112);
        chk_int("clean.u0.press_count", cnt_press[0], 1);

        // Press bounce
        clear_counts();
        for (int c = 0; c < 30; c++) begin
            p = ((c / 3) % 2 == 0) ? 3'b111 : 3'b000;
            step("bounce");
        end
        run("bounce", 3'b000, 30);
        run("short", 3'b111, 19);
        run("short", 3'b000, 30);
        chk_int("bounce.u0.press_count", cnt_press[0], 0);
        chk_int("bounce.u1.press_count", cnt_press[1], 0);
        chk_int("bounce.u0.release_count", cnt_rel[0], 0);

        // Release bounce
        clear_counts();
        run("relb", 3'b111, 40);
        run("relb", 3'b000, 5);
        run("relb", 3'b111, 30);
        chk_int("relb.u0.press_count", cnt_press[0], 1);
        chk_int("relb.u0.release_count", cnt_rel[0], 0);
        run("relb", 3'b000, 40);
        chk_int("relb.u0.release_after", cnt_rel[0], 1);

        // Long press
        clear_counts();
        run("long", 3'b111, 1500);
        run("long", 3'b000, 40);
        chk_int("long.u0.press_count", cnt_press[0], 1);
        chk_int("long.u0.release_count", cnt_rel[0], 1);
`ifdef BTN_LONGPRESS_EN
        chk_int("long.u0.long_count", cnt_long[0], 1);
        chk_int("long.u0.long_delay", last_long[0] - last_press[0], 1000);
`else
        chk_int("long.u0.long_count", cnt_long[0], 0);
`endif

        // Reset mid PRESS_WAIT with the button still held
        run("rstmid", 3'b111, 10);
        hit_reset(3);
        clear_counts();
        run("rstmid", 3'b111, 30);
        chk_int("rstmid.u0.press_edge", last_press[0], 22);
        chk_int("rstmid.u1.press_edge", last_press[1], 22);

        // Reset lands while press_pulse is high
        run("cut", 3'b000, 40);
        p = 3'b111;
        for (int c = 0; c < 40; c++) begin
            step("cut");
            if (press_o[0] === 1'b1) break;
        end
        chk("cut.pulse_seen", press_o[0], 1'b1);
        hit_reset(2);
        chk("cut.press_cleared", press_o[0], 1'b0);

        // Random runs, short bursts act as bounce
        for (int i = 0; i < 3; i++) rl[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (rl[i] == 0) begin
                    p[i] = ~p[i];
                    rl[i] = ($urandom_range(0, 3) == 0) ?
                            int'($urandom_range(1, 4)) : int'($urandom_range(5, 45));
                end
                rl[i]--;
            end
            if ($urandom_range(0, 999) == 0) hit_reset(2);
            else step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream front-end for the stopwatch push-buttons (start/stop, clear). Runs in the 1 kHz clk domain.
- Takes a raw, bouncing, asynchronous button pin and produces clean single-cycle events plus a debounced level.
- press_pulse drives the stopwatch start input directly. long_pulse is intended for a hold-to-clear function.

Parameters:
- DEBOUNCE_MS, 20: consecutive stable samples needed to accept a press or a release. Legal range >= 1.
- LONG_MS, 1000: cycles in the held state before long_pulse fires. Must be > DEBOUNCE_MS.
- ACTIVE_LOW, 0: 1 means btn_in is inverted at the input, so pin low = pressed.

Ports:
- clk, input, 1: 1 kHz system clock.
- rst, input, 1: reset, asynchronous, active-high.
- btn_in, input, 1: raw button pin. Asynchronous and may bounce.
- btn_level, output, 1: debounced pressed level.
- press_pulse, output, 1: one-cycle pulse on an accepted press.
- release_pulse, output, 1: one-cycle pulse on an accepted release.
- long_pulse, output, 1: one-cycle pulse when a press is held for LONG_MS cycles.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Sync flops hold the "not pressed" value.
  - All counters 0.
- Input path:
  - Optional inversion (ACTIVE_LOW), then a 2-flop synchronizer producing s_in.
  - The FSM uses only s_in.
- Counters:
  - Debounce counter width is clog2(DEBOUNCE_MS+1).
  - Hold counter width is clog2(LONG_MS+1). It saturates at LONG_MS and never wraps.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - s_in=1: go to PRESS_WAIT, deb_cnt=1. If DEBOUNCE_MS==1, go directly to HELD as below.
- PRESS_WAIT:
  - s_in=0: go to IDLE, deb_cnt=0, no output.
  - s_in=1 and deb_cnt==DEBOUNCE_MS-1: go to HELD. press_pulse=1 for one cycle. btn_level=1. hold_cnt=0.
  - s_in=1 otherwise: deb_cnt increments.
- HELD:
  - hold_cnt increments every cycle.
  - s_in=0: go to RELEASE_WAIT, deb_cnt=1.
- RELEASE_WAIT:
  - hold_cnt keeps incrementing.
  - s_in=1 (bounce): return to HELD, deb_cnt=0, no pulse, btn_level stays 1.
  - s_in=0 and deb_cnt==DEBOUNCE_MS-1: go to IDLE. release_pulse=1 for one cycle. btn_level=0.
  - s_in=0 otherwise: deb_cnt increments.
- Latency:
  - btn_in is first sampled active at edge k and held stable.
  - press_pulse is high in the cycle after edge k+1+DEBOUNCE_MS.
  - Release has the same latency.
- Pulses:
  - Registered outputs, exactly one clk cycle wide, never back-to-back from the same event.
  - press_pulse and release_pulse can never be high in the same cycle.
- Reset mid-operation:
  - Asynchronous return to the reset values; any in-progress pulse is cut.
  - A button still held after rst deasserts is treated as a new press: it is debounced from zero and then produces press_pulse.

Optional Feature:
- Macro: BTN_LONGPRESS_EN.
- Defined:
  - hold_cnt is present.
  - long_pulse=1 for one cycle on the edge where hold_cnt reaches LONG_MS while in HELD or RELEASE_WAIT. This is LONG_MS cycles after press_pulse.
  - It fires at most once per press. The flag is cleared on return to IDLE.
  - release_pulse still occurs on release.
- Undefined:
  - hold_cnt is removed.
  - long_pulse is tied to 0.
  - All other behaviour is identical.

Test Plan (default parameters):
1. Clean press:
   - Stimulus: rst, then btn_in=1 sampled from edge 10, held to edge 110, then 0.
   - Required: press_pulse high one cycle after edge 31, and btn_level=1 from then. release_pulse high one cycle after edge 131, and btn_level=0 from then.
2. Press bounce:
   - Stimulus: btn_in toggles every 3 cycles for 30 cycles, then stays 0.
   - Required: no pulses, btn_level=0 throughout. Also, btn_in=1 for only 19 cycles must give no press_pulse.
3. Release bounce:
   - Stimulus: while HELD, btn_in=0 for 5 cycles, then 1 again.
   - Required: no release_pulse, btn_level stays 1, no second press_pulse.
4. Long press, BTN_LONGPRESS_EN defined:
   - Stimulus: btn_in=1 from edge 10 for 1500 cycles.
   - Required: press_pulse after edge 31. long_pulse exactly once, after edge 1031. release_pulse after release plus 21 edges.
   - Same stimulus with the macro undefined: long_pulse stays 0.
5. Reset mid-operation:
   - Stimulus: rst pulsed during PRESS_WAIT with btn_in held 1.
   - Required: all outputs 0 immediately. press_pulse after edge k+21, where k is the first edge after rst deasserts.
6. ACTIVE_LOW=1:
   - Stimulus: btn_in idles 1, goes to 0 from edge 10 and is held.
   - Required: no pulses while btn_in idles at 1. press_pulse after edge 31.
